// File: rtl/uart_tx_fifo.sv
// UART transmitter (LSB-first, 1 start/DBIT data/stop) fed by a 2**FIFO_AW byte FIFO, 16x oversampled baud.
// Latency: frame start (oTx low) 2 clk after a push into an empty idle block; frames back-to-back with 1 idle clk.
// Backpressure: pushes are dropped while oFull is high. Define UART_TX_PARITY_EN to insert an even parity bit.
module uart_tx_fifo #(
    parameter int DBIT    = 8,
    parameter int SB_TICK = 16,
    parameter int DVSR    = 326,
    parameter int FIFO_AW = 4
) (
    input  logic            iClk,
    input  logic            iRst,
    input  logic [DBIT-1:0] iWrData,
    input  logic            iWrEn,
    output logic            oFull,
    output logic            oEmpty,
    output logic            oBusy,
    output logic            oTx
);

    localparam int BW = (DVSR > 1) ? $clog2(DVSR) : 1;
    localparam int SW = (SB_TICK > 16) ? $clog2(SB_TICK) : 4;
    localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

    localparam logic [BW-1:0]      BAUD_LAST = BW'(DVSR - 1);
    localparam logic [BW-1:0]      BAUD_ONE  = BW'(1);
    localparam logic [SW-1:0]      S_BIT_LAST  = SW'(15);
    localparam logic [SW-1:0]      S_STOP_LAST = SW'(SB_TICK - 1);
    localparam logic [SW-1:0]      S_ONE     = SW'(1);
    localparam logic [NW-1:0]      N_LAST    = NW'(DBIT - 1);
    localparam logic [NW-1:0]      N_ONE     = NW'(1);
    localparam logic [FIFO_AW-1:0] PTR_ONE   = FIFO_AW'(1);
    localparam logic [FIFO_AW:0]   CNT_ONE   = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW:0]   CNT_FULL  = {1'b1, {FIFO_AW{1'b0}}};

`ifdef UART_TX_PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t             state;
    logic [BW-1:0]      baud;
    logic [SW-1:0]      s;
    logic [NW-1:0]      n;
    logic [DBIT-1:0]    shift;
    logic               tx;
    logic [FIFO_AW-1:0] wr_ptr;
    logic [FIFO_AW-1:0] rd_ptr;
    logic [FIFO_AW:0]   count;
    logic [DBIT-1:0]    mem [2**FIFO_AW];
`ifdef UART_TX_PARITY_EN
    logic               parity;
`endif

    logic tick;
    logic push;
    logic pop;

    assign oFull  = (count == CNT_FULL);
    assign oEmpty = (count == '0);
    assign oBusy  = (state != IDLE);
    assign oTx    = tx;

    assign push = iWrEn && !oFull;
    assign pop  = (state == IDLE) && !oEmpty;
    assign tick = (state != IDLE) && (baud == BAUD_LAST);

    always_ff @(posedge iClk) begin
        if (push) begin
            mem[wr_ptr] <= iWrData;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            if (push && !pop)      count <= count + CNT_ONE;
            else if (pop && !push) count <= count - CNT_ONE;
        end
    end

    // Held at zero while idle so every bit is timed from the start-bit edge.
    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            baud <= '0;
        end else if (state == IDLE || tick) begin
            baud <= '0;
        end else begin
            baud <= baud + BAUD_ONE;
        end
    end

    always_ff @(posedge iClk or negedge iRst) begin
        if (!iRst) begin
            state  <= IDLE;
            s      <= '0;
            n      <= '0;
            shift  <= '0;
            tx     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            parity <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    tx <= 1'b1;
                    if (!oEmpty) begin
                        shift  <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
                        parity <= ^mem[rd_ptr];
`endif
                        s      <= '0;
                        tx     <= 1'b0;
                        state  <= START;
                    end
                end
                START: begin
                    if (tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            n     <= '0;
                            tx    <= shift[0];
                            state <= DATA;
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
                DATA: begin
                    if (tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            shift <= shift >> 1;
                            if (n == N_LAST) begin
`ifdef UART_TX_PARITY_EN
                                tx    <= parity;
                                state <= PARITY;
`else
                                tx    <= 1'b1;
                                state <= STOP;
`endif
                            end else begin
                                n  <= n + N_ONE;
                                tx <= shift[1];
                            end
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (tick) begin
                        if (s == S_BIT_LAST) begin
                            s     <= '0;
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
`endif
                STOP: begin
                    if (tick) begin
                        if (s == S_STOP_LAST) begin
                            s     <= '0;
                            state <= IDLE;
                        end else begin
                            s <= s + S_ONE;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a short baud divisor so whole frames fit in a quick run.
module tb_uart_tx_fifo;

    localparam int DVSR = 4;
    localparam int BIT  = 16 * DVSR;
`ifdef UART_TX_PARITY_EN
    localparam int FRAME_BITS = 11;
`else
    localparam int FRAME_BITS = 10;
`endif

    logic       iClk = 1'b0;
    logic       iRst = 1'b0;
    logic [7:0] iWrData = 8'h00;
    logic       iWrEn = 1'b0;
    logic       oFull;
    logic       oEmpty;
    logic       oBusy;
    logic       oTx;

    int n_checks = 0;
    int n_pass   = 0;

    uart_tx_fifo #(
        .DBIT(8),
        .SB_TICK(16),
        .DVSR(DVSR),
        .FIFO_AW(4)
    ) dut (
        .iClk(iClk),
        .iRst(iRst),
        .iWrData(iWrData),
        .iWrEn(iWrEn),
        .oFull(oFull),
        .oEmpty(oEmpty),
        .oBusy(oBusy),
        .oTx(oTx)
    );

    always #5 iClk = ~iClk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iClk);
        #1;
    endtask

    function automatic logic exp_bit(input logic [7:0] b, input int i);
        if (i == 0) return 1'b0;
        if (i <= 8) return b[i-1];
`ifdef UART_TX_PARITY_EN
        if (i == 9) return ^b;
`endif
        return 1'b1;
    endfunction

    // Entered one step after the edge that drove the start bit; returns in the idle clock after stop.
    task automatic check_frame(input logic [7:0] b);
        for (int i = 0; i < FRAME_BITS; i++) begin
            chk($sformatf("frame %02h bit%0d first clk", b, i), oTx, exp_bit(b, i));
            tick(BIT - 1);
            chk($sformatf("frame %02h bit%0d last clk", b, i), oTx, exp_bit(b, i));
            if (i == FRAME_BITS - 1) chk($sformatf("frame %02h busy at end", b), oBusy, 1);
            tick(1);
        end
        chk($sformatf("frame %02h busy after", b), oBusy, 0);
        chk($sformatf("frame %02h line idle after", b), oTx, 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: bench did not complete");
        $fatal(1);
    end

    initial begin
        logic idle_ok;

        #23;
        chk("reset tx", oTx, 1);
        chk("reset busy", oBusy, 0);
        chk("reset full", oFull, 0);
        chk("reset empty", oEmpty, 1);
        @(posedge iClk); #1;
        iRst = 1'b1;
        tick(3);
        chk("post-reset tx", oTx, 1);
        chk("post-reset empty", oEmpty, 1);

        // Single byte: 2 clk push-to-start latency then a full frame.
        iWrData = 8'h55; iWrEn = 1'b1;
        tick(1);
        iWrEn = 1'b0;
        chk("t1 edge1 tx", oTx, 1);
        chk("t1 edge1 empty", oEmpty, 0);
        chk("t1 edge1 busy", oBusy, 0);
        tick(1);
        chk("t1 edge2 busy", oBusy, 1);
        chk("t1 edge2 empty", oEmpty, 1);
        check_frame(8'h55);
        chk("t1 empty after", oEmpty, 1);

        // Lead byte 0x00, then 0x01..0x10 on consecutive clocks (first one lands on the pop edge).
        iWrData = 8'h00; iWrEn = 1'b1;
        tick(1);
        iWrData = 8'h01;
        tick(1);
        chk("push+pop same cycle empty", oEmpty, 0);
        chk("push+pop same cycle busy", oBusy, 1);
        fork
            begin
                for (int k = 2; k <= 16; k++) begin
                    iWrData = 8'(k);
                    tick(1);
                    if (k == 15) chk("full after 15 pushes", oFull, 0);
                end
                chk("full after 16 pushes", oFull, 1);
                iWrData = 8'hAA;
                tick(1);
                iWrEn = 1'b0;
                chk("full after dropped push", oFull, 1);
            end
            begin
                check_frame(8'h00);
                for (int b = 1; b <= 16; b++) begin
                    tick(1);
                    check_frame(8'(b));
                end
            end
        join
        chk("t2 empty after drain", oEmpty, 1);
        chk("t2 full after drain", oFull, 0);
        idle_ok = 1'b1;
        for (int i = 0; i < 2 * BIT; i++) begin
            if (oTx !== 1'b1 || oBusy !== 1'b0) idle_ok = 1'b0;
            tick(1);
        end
        chk("dropped byte never sent", idle_ok, 1);

        // Reset in data bit 3 of 0xF0 with 0x33 queued behind it.
        iWrData = 8'hF0; iWrEn = 1'b1;
        tick(1);
        iWrData = 8'h33;
        tick(1);
        iWrEn = 1'b0;
        tick(4 * BIT + BIT / 2);
        chk("t4 data bit3 low", oTx, 0);
        chk("t4 queued byte", oEmpty, 0);
        iRst = 1'b0;
        #1;
        chk("t4 async reset tx", oTx, 1);
        chk("t4 async reset busy", oBusy, 0);
        chk("t4 async reset empty", oEmpty, 1);
        chk("t4 async reset full", oFull, 0);
        tick(2);
        iRst = 1'b1;
        idle_ok = 1'b1;
        for (int i = 0; i < 3 * BIT; i++) begin
            if (oTx !== 1'b1 || oBusy !== 1'b0 || oEmpty !== 1'b1) idle_ok = 1'b0;
            tick(1);
        end
        chk("t4 idle after release", idle_ok, 1);
        iWrData = 8'h3C; iWrEn = 1'b1;
        tick(1);
        iWrEn = 1'b0;
        tick(1);
        chk("t4 restart busy", oBusy, 1);
        check_frame(8'h3C);

`ifdef UART_TX_PARITY_EN
        iWrData = 8'h07; iWrEn = 1'b1;
        tick(1);
        iWrData = 8'h03;
        tick(1);
        iWrEn = 1'b0;
        check_frame(8'h07);
        tick(1);
        check_frame(8'h03);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
